seg_scan_ctrl: RTL and testbench

//  Scan controller for the Basys3 4-digit common-anode seven-segment display.

---
 rtl/seg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Guard gaps between digits suppress ghosting; new words take effect only at frame boundaries.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        lz_blank,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic        upd_ready,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  logic [1:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [1:0]       digit, nxt_digit;
  logic [15:0]      active_word, nxt_word, pend_word;
  logic [3:0]       active_dp, nxt_dp, pend_dp;
  logic             pend_full;
  logic             boundary, move, xfer;
  logic [3:0]       nib;
  logic             blank;
  logic [7:0]       drive_seg;
  logic [3:0]       drive_an;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Next-state logic; disabling from any state returns to OFF with counters cleared.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_digit = digit;
    boundary  = 1'b0;
    if (!en) begin
      nxt_state = S_OFF;
      nxt_cnt   = '0;
      nxt_digit = 2'd0;
    end else begin
      case (state)
        S_OFF: begin
          nxt_state = S_GUARD;
          nxt_cnt   = '0;
          nxt_digit = 2'd0;
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            nxt_state = S_DRIVE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            nxt_state = S_GUARD;
            nxt_cnt   = '0;
            nxt_digit = digit + 2'd1;
            boundary  = (digit == 2'd3);
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = S_OFF;
          nxt_cnt   = '0;
          nxt_digit = 2'd0;
        end
      endcase
    end
  end

  // Pending word is promoted at a frame boundary, or immediately while the display is off.
  always_comb begin
    xfer     = upd_valid && upd_ready;
    move     = pend_full && (boundary || (state == S_OFF));
    nxt_word = move ? pend_word : active_word;
    nxt_dp   = move ? pend_dp : active_dp;
    nib      = nxt_word[{nxt_digit, 2'b00} +: 4];
    case (nxt_digit)
      2'd1:    blank = (nxt_word[15:4] == 12'h000);
      2'd2:    blank = (nxt_word[15:8] == 8'h00);
      2'd3:    blank = (nxt_word[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    drive_seg = {~nxt_dp[nxt_digit], (lz_blank && blank) ? 7'h7F : hex7(nib)};
    drive_an  = ~(4'b0001 << nxt_digit);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_OFF;
      cnt         <= '0;
      digit       <= 2'd0;
      active_word <= 16'h0000;
      active_dp   <= 4'h0;
      pend_word   <= 16'h0000;
      pend_dp     <= 4'h0;
      pend_full   <= 1'b0;
      upd_ready   <= 1'b1;
      frame_tick  <= 1'b0;
      seg         <= 8'hFF;
      an          <= 4'hF;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      digit       <= nxt_digit;
      active_word <= nxt_word;
      active_dp   <= nxt_dp;
      frame_tick  <= boundary;
      if (move)
        pend_full <= 1'b0;
      if (xfer) begin
        pend_word <= upd_data;
        pend_dp   <= upd_dp;
        pend_full <= 1'b1;
      end
      // Ready returns one edge after the buffer empties, limiting intake to one word per frame.
      if (xfer)
        upd_ready <= 1'b0;
      else if (!pend_full)
        upd_ready <= 1'b1;
      if (nxt_state == S_DRIVE) begin
        seg <= drive_seg;
        an  <= drive_an;
      end else begin
        seg <= 8'hFF;
        an  <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with short timing (REFRESH_DIV=4, GUARD_CYC=2).
// Expected digit patterns are queued when a word is written and compared as frames are scanned.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        lz_blank = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0000;
  logic [3:0]  upd_dp = 4'h0;
  logic        upd_ready;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  seg_scan_ctrl #(.REFRESH_DIV(4), .GUARD_CYC(2)) dut (
    .clk(clk), .reset(reset), .en(en), .lz_blank(lz_blank),
    .upd_valid(upd_valid), .upd_data(upd_data), .upd_dp(upd_dp),
    .upd_ready(upd_ready), .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [6:0] hexSeg(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  function automatic logic [11:0] expDigit(input logic [15:0] w, input logic [3:0] dp,
                                           input logic lz, input int i);
    logic [3:0]  nibv;
    logic [3:0]  anv;
    logic [15:0] upper;
    logic        blank;
    nibv  = w[i*4 +: 4];
    upper = w >> (4 * i);
    blank = lz && (i > 0) && (upper == 16'h0000);
    anv   = 4'b0001 << i;
    return {~anv, ~dp[i], blank ? 7'h7F : hexSeg(nibv)};
  endfunction

  task automatic pushFrame(input logic [15:0] w, input logic [3:0] dp, input logic lz);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(expDigit(w, dp, lz, i));
  endtask

  // Offers a word at a negedge and returns on the negedge after it has been accepted.
  task automatic applyStimulus(input logic [15:0] w, input logic [3:0] dp);
    int n;
    upd_valid = 1'b1;
    upd_data  = w;
    upd_dp    = dp;
    n = 0;
    while (upd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("accept_%h", w), upd_ready, 1'b1);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // Waits for the next frame_tick, then compares the four digits of the frame that follows.
  task automatic observeFrame(input string tag);
    int n;
    logic [11:0] expv;
    @(negedge clk);
    n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_tick"}, frame_tick, 1'b1);
    for (int d = 0; d < 4; d++) begin
      n = 0;
      while (an === 4'hF && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        expv = exp_q.pop_front();
        checkOutput($sformatf("%s_d%0d", tag, d), {an, seg}, expv);
      end
      n = 0;
      while (an !== 4'hF && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  initial begin
    logic [3:0] exp_an [8];
    int n;
    exp_an = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF};

    // Reset held with enable high
    en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_an", an, 4'hF);
    checkOutput("rst_seg", seg, 8'hFF);
    checkOutput("rst_ready", upd_ready, 1'b1);
    checkOutput("rst_tick", frame_tick, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("start_an%0d", k), an, exp_an[k]);
      if (k == 2)
        checkOutput("start_seg0", seg, 8'hC0);
    end

    // Write while dark: move happens on the cycle after capture
    en = 1'b0;
    @(negedge clk);
    checkOutput("dark_an", an, 4'hF);
    applyStimulus(16'h1234, 4'h0);
    checkOutput("off_ready_fall", upd_ready, 1'b0);
    @(negedge clk);
    checkOutput("off_ready_move", upd_ready, 1'b0);
    @(negedge clk);
    checkOutput("off_ready_rise", upd_ready, 1'b1);
    pushFrame(16'h1234, 4'h0, 1'b0);
    en = 1'b1;
    observeFrame("f1234");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    checkOutput("tick_period", n, 24);

    // Back-to-back writes during scanning
    applyStimulus(16'hABCD, 4'h0);
    checkOutput("busy_ready", upd_ready, 1'b0);
    fork
      applyStimulus(16'h0000, 4'h0);
    join_none
    pushFrame(16'hABCD, 4'h0, 1'b0);
    pushFrame(16'h0000, 4'h0, 1'b0);
    observeFrame("fABCD");
    checkOutput("backpressure", upd_ready, 1'b0);
    observeFrame("f0000");
    wait fork;

    // Leading-zero blanking with a decimal point on digit 0
    lz_blank = 1'b1;
    applyStimulus(16'h0050, 4'b0001);
    pushFrame(16'h0050, 4'b0001, 1'b1);
    observeFrame("f0050");

    // Drop enable while digit 2 is driven, then restart
    n = 0;
    while (an !== 4'b1011 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_d2", an, 4'b1011);
    en = 1'b0;
    @(negedge clk);
    checkOutput("drop_an", an, 4'hF);
    checkOutput("drop_seg", seg, 8'hFF);
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checkOutput("re_an0", an, 4'hF);
    @(negedge clk);
    checkOutput("re_an1", an, 4'hF);
    @(negedge clk);
    checkOutput("re_an2", an, 4'hE);
    checkOutput("re_seg", seg, 8'h40);

    // Reset with a word pending
    lz_blank = 1'b0;
    applyStimulus(16'h9999, 4'hF);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ready", upd_ready, 1'b1);
    checkOutput("mid_rst_an", an, 4'hF);
    checkOutput("mid_rst_seg", seg, 8'hFF);
    reset = 1'b1;
    pushFrame(16'h0000, 4'h0, 1'b0);
    observeFrame("after_rst");
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
